bank_req_router: RTL and testbench
==================================

BANK_REQ_ROUTER -- requirements
Module: bank_req_router

Interface
REQ-001 Parameters SHALL be:
- ADDR_WIDTH, 32, global address width.
- NUM_MODULES, 8, bank count (power of 2).
- LOCAL_ADDR_WIDTH, 10, in-bank address width.
- MOD_ID_BITS, 3, log2(NUM_MODULES).
- DATA_WIDTH, 32, data width.
- BANK_LATENCY, 2, bank read latency in cycles (>=1).

REQ-002 Ports SHALL be:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- hash_sel  in  3  bank hash select: 0 identity, 1 bit-reverse, 2 rotate-left-1, others identity.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when high with req_valid.
- req_addr  in  ADDR_WIDTH  global address.
- req_we  in  1  1 = write, 0 = read.
- req_wdata  in  DATA_WIDTH  write data.
- bank_en  out  NUM_MODULES  one-hot bank strobe.
- bank_we  out  1  write strobe qualifier.
- bank_addr  out  LOCAL_ADDR_WIDTH  in-bank address.
- bank_wdata  out  DATA_WIDTH  write data to bank.
- bank_rdata  in  NUM_MODULES*DATA_WIDTH  flattened read data; bank k occupies slice k.
- rsp_valid  out  1  read response strobe, one cycle, no backpressure.
- rsp_rdata  out  DATA_WIDTH  read data.
- rsp_module_id  out  MOD_ID_BITS  bank that served the response.
- conflict_cnt  out  16  saturating count of bank-conflict stall cycles.

Function
REQ-003 Target bank and local address SHALL be derived combinationally from req_addr and hash_sel: bank field = req_addr[LOCAL_ADDR_WIDTH+MOD_ID_BITS-1:LOCAL_ADDR_WIDTH], local = req_addr[LOCAL_ADDR_WIDTH-1:0], then hash applied to the bank field.
REQ-004 Each bank SHALL have a busy counter (0..BANK_LATENCY).
REQ-005 req_ready SHALL equal busy counter of the currently targeted bank == 0; it SHALL be combinational and SHALL NOT depend on req_valid.
REQ-006 On acceptance at edge T, the target bank's busy counter SHALL load BANK_LATENCY; every nonzero counter SHALL decrement by 1 per cycle.
REQ-007 Next acceptance to the same bank SHALL be possible no earlier than edge T+BANK_LATENCY+1; requests to different banks SHALL be acceptable on consecutive edges.
REQ-008 The cycle after acceptance (cycle E = T+1), bank_en SHALL be one-hot on the target bank and bank_we/bank_addr/bank_wdata SHALL be registered copies of the request; with no acceptance, bank_en SHALL be all zero.
REQ-009 For reads, the router SHALL capture bank_rdata slice of the target bank at the end of cycle E+BANK_LATENCY, then pulse rsp_valid for exactly one cycle in cycle E+BANK_LATENCY+1 with rsp_rdata and rsp_module_id.
REQ-010 Writes SHALL produce no response.
REQ-011 Response tracking SHALL use a BANK_LATENCY+1 deep shift pipeline of {valid, module_id}; responses SHALL be in acceptance order, at most one per cycle.
REQ-012 conflict_cnt SHALL increment every cycle with req_valid && !req_ready, saturating at 16'hFFFF.
REQ-013 hash_sel changes SHALL take effect for the next acceptance; in-flight responses keep their captured module_id.
REQ-014 A read and a write to different banks in consecutive cycles SHALL both issue normally.

Reset
REQ-015 While rst is high, the block SHALL drive:
- bank_en = 0, bank_we = 0, bank_addr = 0, bank_wdata = 0.
- rsp_valid = 0, rsp_rdata = 0, rsp_module_id = 0.
- conflict_cnt = 0.
- All busy counters and pipeline valids = 0.
REQ-016 Reset asserted mid-operation SHALL discard all in-flight reads; no rsp_valid SHALL appear for them after reset release.
REQ-017 After reset, req_ready SHALL be 1 for any target.

Structure
REQ-018 Hash-select encodings (IDENTITY = 0, REVERSE = 1, ROTL = 2) and default widths SHALL live in a shared package, mem_pkg.
REQ-019 Address decode SHALL instantiate the existing address splitter as the one sub-module; hashing logic SHALL NOT be duplicated.

Verification
REQ-020 Reset, then read 0x0000_0405 with hash_sel = 0 accepted at T:
- bank_en = 8'b0000_0010, bank_addr = 5 at T+1.
- rsp_valid at T+4, rsp_module_id = 1.
REQ-021 Same address with hash_sel = 1 -> bank_en = 8'b0001_0000; with hash_sel = 2 -> bank_en = 8'b0000_0100.
REQ-022 Reads to 0x0405 on consecutive edges (same bank 1):
- req_ready low for 2 cycles after first accept.
- conflict_cnt = 2.
- Second accept at T+3.
REQ-023 Reads to banks 0..7 on 8 consecutive edges:
- No stall.
- 8 back-to-back rsp_valid pulses in bank order, each carrying its bank's rdata.
REQ-024 Write to 0x0C05 (bank 3):
- bank_en = 8'b0000_1000, bank_we = 1, bank_wdata = req_wdata.
- No rsp_valid.
REQ-025 Assert rst one cycle after a read accept -> bank_en, rsp_valid and conflict_cnt are 0; no response after release; req_ready = 1.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared memory-subsystem definitions: hash-select encodings and default
// geometry for the banked request router.
package mem_pkg;

    localparam int ADDR_WIDTH_DEF       = 32;
    localparam int NUM_MODULES_DEF      = 8;
    localparam int LOCAL_ADDR_WIDTH_DEF = 10;
    localparam int MOD_ID_BITS_DEF      = 3;
    localparam int DATA_WIDTH_DEF       = 32;
    localparam int BANK_LATENCY_DEF     = 2;

    typedef enum logic [2:0] {
        HASH_IDENTITY = 3'd0,
        HASH_REVERSE  = 3'd1,
        HASH_ROTL     = 3'd2
    } hash_sel_e;

endpackage

// File: rtl/bank_req_router_addr_split.sv
// Address splitter: extracts the bank field and in-bank offset from a global
// address and applies the selected bank hash to the bank field.
module bank_req_router_addr_split
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH       = ADDR_WIDTH_DEF,
    parameter int LOCAL_ADDR_WIDTH = LOCAL_ADDR_WIDTH_DEF,
    parameter int MOD_ID_BITS      = MOD_ID_BITS_DEF
) (
    input  logic [ADDR_WIDTH-1:0]       addr,
    input  logic [2:0]                  hash_sel,
    output logic [MOD_ID_BITS-1:0]      module_id,
    output logic [LOCAL_ADDR_WIDTH-1:0] local_addr
);

    logic [MOD_ID_BITS-1:0] bank_field;

    assign bank_field = addr[LOCAL_ADDR_WIDTH+MOD_ID_BITS-1:LOCAL_ADDR_WIDTH];
    assign local_addr = addr[LOCAL_ADDR_WIDTH-1:0];

    // Unknown hash selects fall back to identity.
    always_comb begin
        module_id = bank_field;
        case (hash_sel)
            HASH_REVERSE: begin
                for (int i = 0; i < MOD_ID_BITS; i++) begin
                    module_id[i] = bank_field[MOD_ID_BITS-1-i];
                end
            end
            HASH_ROTL: begin
                for (int i = 0; i < MOD_ID_BITS; i++) begin
                    module_id[(i+1) % MOD_ID_BITS] = bank_field[i];
                end
            end
            default: ;
        endcase
    end

    // Address bits above the bank field do not select anything.
    generate
        if (ADDR_WIDTH > LOCAL_ADDR_WIDTH + MOD_ID_BITS) begin : g_upper
            logic unused_upper;
            assign unused_upper = ^addr[ADDR_WIDTH-1:LOCAL_ADDR_WIDTH+MOD_ID_BITS];
        end
    endgenerate

endmodule

// File: rtl/bank_req_router.sv
// Banked request router: routes one request per cycle to a hashed bank,
// enforces per-bank occupancy and returns read data in acceptance order.
module bank_req_router
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH       = ADDR_WIDTH_DEF,
    parameter int NUM_MODULES      = NUM_MODULES_DEF,
    parameter int LOCAL_ADDR_WIDTH = LOCAL_ADDR_WIDTH_DEF,
    parameter int MOD_ID_BITS      = MOD_ID_BITS_DEF,
    parameter int DATA_WIDTH       = DATA_WIDTH_DEF,
    parameter int BANK_LATENCY     = BANK_LATENCY_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [2:0]                        hash_sel,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [ADDR_WIDTH-1:0]             req_addr,
    input  logic                              req_we,
    input  logic [DATA_WIDTH-1:0]             req_wdata,
    output logic [NUM_MODULES-1:0]            bank_en,
    output logic                              bank_we,
    output logic [LOCAL_ADDR_WIDTH-1:0]       bank_addr,
    output logic [DATA_WIDTH-1:0]             bank_wdata,
    input  logic [NUM_MODULES*DATA_WIDTH-1:0] bank_rdata,
    output logic                              rsp_valid,
    output logic [DATA_WIDTH-1:0]             rsp_rdata,
    output logic [MOD_ID_BITS-1:0]            rsp_module_id,
    output logic [15:0]                       conflict_cnt
);

    localparam int BUSY_BITS = $clog2(BANK_LATENCY + 1);

    logic [MOD_ID_BITS-1:0]      tgt_id;
    logic [LOCAL_ADDR_WIDTH-1:0] tgt_local;
    logic                        accept;
    logic [BUSY_BITS-1:0]        busy       [NUM_MODULES];
    logic                        pipe_valid [BANK_LATENCY+1];
    logic [MOD_ID_BITS-1:0]      pipe_id    [BANK_LATENCY+1];
    logic [DATA_WIDTH-1:0]       rdata_arr  [NUM_MODULES];

    bank_req_router_addr_split #(
        .ADDR_WIDTH       (ADDR_WIDTH),
        .LOCAL_ADDR_WIDTH (LOCAL_ADDR_WIDTH),
        .MOD_ID_BITS      (MOD_ID_BITS)
    ) u_addr_split (
        .addr       (req_addr),
        .hash_sel   (hash_sel),
        .module_id  (tgt_id),
        .local_addr (tgt_local)
    );

    assign req_ready = (busy[tgt_id] == '0);
    assign accept    = req_valid && req_ready;

    always_comb begin
        for (int k = 0; k < NUM_MODULES; k++) begin
            rdata_arr[k] = bank_rdata[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // A bank stays busy for BANK_LATENCY cycles after each accepted access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_MODULES; k++) begin
                busy[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_MODULES; k++) begin
                if (accept && (tgt_id == MOD_ID_BITS'(k))) begin
                    busy[k] <= BUSY_BITS'(BANK_LATENCY);
                end else if (busy[k] != '0) begin
                    busy[k] <= busy[k] - BUSY_BITS'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_en    <= '0;
            bank_we    <= 1'b0;
            bank_addr  <= '0;
            bank_wdata <= '0;
        end else begin
            bank_en <= '0;
            bank_we <= accept && req_we;
            if (accept) begin
                bank_en[tgt_id] <= 1'b1;
                bank_addr       <= tgt_local;
                bank_wdata      <= req_wdata;
            end
        end
    end

    // The last stage lines up with the edge that ends the bank's read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= BANK_LATENCY; i++) begin
                pipe_valid[i] <= 1'b0;
                pipe_id[i]    <= '0;
            end
        end else begin
            pipe_valid[0] <= accept && !req_we;
            pipe_id[0]    <= tgt_id;
            for (int i = 1; i <= BANK_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_id[i]    <= pipe_id[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_module_id <= '0;
        end else begin
            rsp_valid <= pipe_valid[BANK_LATENCY];
            if (pipe_valid[BANK_LATENCY]) begin
                rsp_rdata     <= rdata_arr[pipe_id[BANK_LATENCY]];
                rsp_module_id <= pipe_id[BANK_LATENCY];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (req_valid && !req_ready && (conflict_cnt != 16'hFFFF)) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_bank_req_router.sv
// Directed testbench for bank_req_router: a table of single requests plus
// hand-written sequences for stalls, back-to-back banks and mid-flight reset.
module tb_bank_req_router;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   hash_sel;
    logic         req_valid;
    logic         req_ready;
    logic [31:0]  req_addr;
    logic         req_we;
    logic [31:0]  req_wdata;
    logic [7:0]   bank_en;
    logic         bank_we;
    logic [9:0]   bank_addr;
    logic [31:0]  bank_wdata;
    logic [255:0] bank_rdata;
    logic         rsp_valid;
    logic [31:0]  rsp_rdata;
    logic [2:0]   rsp_module_id;
    logic [15:0]  conflict_cnt;

    int check_cnt = 0;
    int pass_cnt  = 0;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  hs;
        logic        we;
        logic [31:0] wdata;
        logic [7:0]  exp_en;
        logic [9:0]  exp_addr;
        logic [2:0]  exp_id;
    } vec_t;

    vec_t vecs [9];

    bank_req_router dut (
        .clk           (clk),
        .rst           (rst),
        .hash_sel      (hash_sel),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_we        (req_we),
        .req_wdata     (req_wdata),
        .bank_en       (bank_en),
        .bank_we       (bank_we),
        .bank_addr     (bank_addr),
        .bank_wdata    (bank_wdata),
        .bank_rdata    (bank_rdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_module_id (rsp_module_id),
        .conflict_cnt  (conflict_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] bank_word(input int k);
        return 32'hB000_0000 + 32'(k);
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [31:0] addr, input logic [2:0] hs,
                             input logic we, input logic [31:0] wdata);
        req_valid = 1'b1;
        req_addr  = addr;
        hash_sel  = hs;
        req_we    = we;
        req_wdata = wdata;
    endtask

    // One request from idle, then the full response window.
    task automatic apply_stimulus(input vec_t v);
        drive_req(v.addr, v.hs, v.we, v.wdata);
        #1;
        check_output("vec_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        check_output("vec_bank_en", 32'(bank_en), 32'(v.exp_en));
        check_output("vec_bank_addr", 32'(bank_addr), 32'(v.exp_addr));
        check_output("vec_bank_we", 32'(bank_we), 32'(v.we));
        if (v.we) check_output("vec_bank_wdata", bank_wdata, v.wdata);
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 1) check_output("vec_bank_en_clear", 32'(bank_en), 32'd0);
            check_output("vec_rsp_valid", 32'(rsp_valid), 32'(!v.we && c == 3));
            if (!v.we && c == 3) begin
                check_output("vec_rsp_id", 32'(rsp_module_id), 32'(v.exp_id));
                check_output("vec_rsp_rdata", rsp_rdata, bank_word(int'(v.exp_id)));
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        hash_sel  = 3'd0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_we    = 1'b0;
        req_wdata = '0;
        for (int k = 0; k < 8; k++) bank_rdata[k*32 +: 32] = bank_word(k);

        vecs[0] = '{32'h0000_0405, 3'd0, 1'b0, 32'h0,         8'b0000_0010, 10'd5,     3'd1};
        vecs[1] = '{32'h0000_0405, 3'd1, 1'b0, 32'h0,         8'b0001_0000, 10'd5,     3'd4};
        vecs[2] = '{32'h0000_0405, 3'd2, 1'b0, 32'h0,         8'b0000_0100, 10'd5,     3'd2};
        vecs[3] = '{32'h0000_0C05, 3'd0, 1'b1, 32'hDEAD_BEEF, 8'b0000_1000, 10'd5,     3'd3};
        vecs[4] = '{32'h0000_1FFF, 3'd0, 1'b0, 32'h0,         8'b1000_0000, 10'h3FF,   3'd7};
        vecs[5] = '{32'hFFFF_E000, 3'd1, 1'b0, 32'h0,         8'b0000_0001, 10'd0,     3'd0};
        vecs[6] = '{32'h0000_0C00, 3'd2, 1'b0, 32'h0,         8'b0100_0000, 10'd0,     3'd6};
        vecs[7] = '{32'h0000_1400, 3'd7, 1'b0, 32'h0,         8'b0010_0000, 10'd0,     3'd5};
        vecs[8] = '{32'h0000_1823, 3'd1, 1'b0, 32'h0,         8'b0000_1000, 10'h023,   3'd3};

        repeat (2) @(posedge clk);
        #1;
        check_output("rst_bank_en", 32'(bank_en), 32'd0);
        check_output("rst_bank_we", 32'(bank_we), 32'd0);
        check_output("rst_bank_addr", 32'(bank_addr), 32'd0);
        check_output("rst_bank_wdata", bank_wdata, 32'd0);
        check_output("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_output("rst_rsp_rdata", rsp_rdata, 32'd0);
        check_output("rst_rsp_id", 32'(rsp_module_id), 32'd0);
        check_output("rst_conflict", 32'(conflict_cnt), 32'd0);
        check_output("rst_ready", 32'(req_ready), 32'd1);
        rst = 1'b0;
        tick();

        foreach (vecs[i]) apply_stimulus(vecs[i]);

        // Same bank on consecutive edges: two stall cycles, second accept at T+3.
        drive_req(32'h0000_0405, 3'd0, 1'b0, 32'h0);
        #1;
        check_output("cf_ready_T", 32'(req_ready), 32'd1);
        tick();
        check_output("cf_en_T", 32'(bank_en), 32'h02);
        check_output("cf_ready_T1", 32'(req_ready), 32'd0);
        tick();
        check_output("cf_en_T1", 32'(bank_en), 32'd0);
        check_output("cf_ready_T2", 32'(req_ready), 32'd0);
        tick();
        check_output("cf_en_T2", 32'(bank_en), 32'd0);
        check_output("cf_ready_T3", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        check_output("cf_en_T3", 32'(bank_en), 32'h02);
        check_output("cf_count", 32'(conflict_cnt), 32'd2);
        repeat (6) tick();

        // All eight banks back to back, responses in bank order.
        for (int c = 0; c < 12; c++) begin
            if (c < 8) begin
                drive_req(32'(c) << 10, 3'd0, 1'b0, 32'h0);
                #1;
                check_output("sw_ready", 32'(req_ready), 32'd1);
            end else begin
                req_valid = 1'b0;
            end
            tick();
            check_output("sw_bank_en", 32'(bank_en), (c < 8) ? (32'd1 << c) : 32'd0);
            check_output("sw_rsp_valid", 32'(rsp_valid), 32'(c >= 3 && c < 11));
            if (c >= 3 && c < 11) begin
                check_output("sw_rsp_id", 32'(rsp_module_id), 32'(c - 3));
                check_output("sw_rsp_rdata", rsp_rdata, bank_word(c - 3));
            end
        end
        check_output("sw_conflict", 32'(conflict_cnt), 32'd2);

        // Read then write to different banks on consecutive edges.
        drive_req(32'h0000_0405, 3'd0, 1'b0, 32'h0);
        tick();
        check_output("rw_en_rd", 32'(bank_en), 32'h02);
        check_output("rw_we_rd", 32'(bank_we), 32'd0);
        drive_req(32'h0000_0C05, 3'd0, 1'b1, 32'h1234_5678);
        tick();
        req_valid = 1'b0;
        check_output("rw_en_wr", 32'(bank_en), 32'h08);
        check_output("rw_we_wr", 32'(bank_we), 32'd1);
        check_output("rw_wdata", bank_wdata, 32'h1234_5678);
        for (int c = 2; c <= 5; c++) begin
            tick();
            check_output("rw_rsp_valid", 32'(rsp_valid), 32'(c == 3));
            if (c == 3) check_output("rw_rsp_id", 32'(rsp_module_id), 32'd1);
        end

        // Reset one cycle after a read accept discards the read.
        drive_req(32'h0000_0405, 3'd0, 1'b0, 32'h0);
        tick();
        req_valid = 1'b0;
        check_output("mr_en_T", 32'(bank_en), 32'h02);
        tick();
        rst = 1'b1;
        #1;
        check_output("mr_bank_en", 32'(bank_en), 32'd0);
        check_output("mr_rsp_valid", 32'(rsp_valid), 32'd0);
        check_output("mr_conflict", 32'(conflict_cnt), 32'd0);
        check_output("mr_ready", 32'(req_ready), 32'd1);
        tick();
        rst = 1'b0;
        #1;
        check_output("mr_ready_rel", 32'(req_ready), 32'd1);
        for (int c = 0; c < 5; c++) begin
            tick();
            check_output("mr_no_rsp", 32'(rsp_valid), 32'd0);
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
